muldiv_seq_unit: RTL and testbench

Iterative, parametrised RV32M/RV64M multiply/divide unit for the EX stage. Executes all eight M-extension operations over multiple cycles behind a START/READY/VALID handshake, freeing the single-cycle ALU from the multiplier and divider critical paths. Division corner cases follow the RISC-V specification exactly. Supports pipeline-flush abort.

---
 rtl/muldiv_seq_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_seq_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, 1 bit per cycle.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier for MUL/MULH/MULHSU/MULHU.
module muldiv_seq_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            kill,
  output logic            ready,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef struct packed {
    logic [2:0] op;
    logic       neg;
  } req_t;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  req_t              req_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc;

  logic              accept;
  logic              s1, s2, is_div;
  logic [XLEN-1:0]   mag1, mag2;
  logic              sc_hit;
  logic [XLEN-1:0]   sc_val;

  assign ready  = ((state == S_IDLE) || (state == S_DONE)) && !kill;
  assign busy   = (state == S_RUN) || (state == S_FIX);
  assign valid  = (state == S_DONE);
  assign accept = start && ready;
  assign is_div = op[2];

  // Operand signs, magnitudes and the short-circuit cases, all decided at accept.
  always_comb begin
    s1 = data1[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM));
    s2 = data2[XLEN-1] & ((op == OP_MULH) | (op == OP_DIV) | (op == OP_REM));
    mag1 = s1 ? (~data1 + 1'b1) : data1;
    mag2 = s2 ? (~data2 + 1'b1) : data2;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fa, fb, fprod;
  always_comb begin
    fa    = $signed({{XLEN{s1}}, data1});
    fb    = $signed({{XLEN{s2}}, data2});
    fprod = fa * fb;
  end
`endif

  always_comb begin
    sc_hit = 1'b0;
    sc_val = '0;
    if (is_div) begin
      if (data2 == '0) begin
        sc_hit = 1'b1;
        sc_val = op[1] ? data1 : '1;
      end else if (op[0] == 1'b0 && data1 == {1'b1, {(XLEN-1){1'b0}}} && data2 == '1) begin
        // Signed overflow: quotient is the dividend, remainder is zero.
        sc_hit = 1'b1;
        sc_val = op[1] ? '0 : data1;
      end
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      sc_hit = 1'b1;
      sc_val = (op == OP_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    end
`endif
  end

  // One iteration step; acc holds {hi, lo} = {partial product, multiplier} or {remainder, quotient}.
  logic              run_div;
  logic [XLEN:0]     mul_sum, r_sh, diff;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    run_div  = req_q.op[2];
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    r_sh     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = r_sh - {1'b0, b_q};
    if (run_div)
      acc_step = diff[XLEN] ? {r_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_step = {mul_sum, acc[XLEN-1:1]};
  end

  // Sign fix and half/quotient/remainder select.
  logic [2*XLEN-1:0] fix_src, fix_neg;
  logic [XLEN-1:0]   fix_val;

  always_comb begin
    if (run_div)
      fix_src = req_q.op[1] ? {{XLEN{1'b0}}, acc[2*XLEN-1:XLEN]} : {{XLEN{1'b0}}, acc[XLEN-1:0]};
    else
      fix_src = acc;
    fix_neg = req_q.neg ? (~fix_src + 1'b1) : fix_src;
    fix_val = (run_div || req_q.op == OP_MUL) ? fix_neg[XLEN-1:0] : fix_neg[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      req_q  <= '0;
      b_q    <= '0;
      acc    <= '0;
      result <= '0;
    end else if (kill) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            req_q.op  <= op;
            req_q.neg <= (is_div && op[1]) ? s1 : (s1 ^ s2);
            b_q       <= is_div ? mag2 : mag1;
            acc       <= {{XLEN{1'b0}}, is_div ? mag1 : mag2};
            cnt       <= '0;
            if (sc_hit) begin
              result <= sc_val;
              state  <= S_DONE;
            end else begin
              state  <= S_RUN;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          acc <= acc_step;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_FIX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_FIX: begin
          result <= fix_val;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for muldiv_seq_unit (XLEN=32): results, latencies, kill, reset, back-to-back.
module tb_muldiv_seq_unit;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 34;
`endif
  localparam int DL = 34;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] data1 = '0, data2 = '0;
  logic        kill = 1'b0;
  logic        ready, busy, valid;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_seq_unit #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .data1(data1), .data2(data2),
    .kill(kill), .ready(ready), .busy(busy), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; data1 = a; data2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    issue(o, a, b);
    wait_valid(n);
    chk(tag, result, exp);
    chk({tag, ".lat"}, 32'(n), 32'(lat));
  endtask

  initial begin
    int n, vcnt;
    #12;
    chk("rst.ready", {31'b0, ready}, 32'd1);
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.valid", {31'b0, valid}, 32'd0);
    chk("rst.result", result, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    run("mulhu.ff", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML);
    run("mul.ff", MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, ML);
    run("mulh.m1m1", MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, ML);
    run("mulhsu.ff", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, ML);
    run("mul.3x5", MUL, 32'd3, 32'd5, 32'd15, ML);
    run("mul.m3x5", MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, ML);
    run("mulh.m3x5", MULH, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, ML);
    run("div.ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("rem.ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run("divu.z", DIVU, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1);
    run("remu.z", REMU, 32'h12345678, 32'h0, 32'h12345678, 1);
    run("div.z", DIV, 32'h87654321, 32'h0, 32'hFFFFFFFF, 1);
    run("rem.z", REM, 32'h87654321, 32'h0, 32'h87654321, 1);
    run("div.m7d2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DL);
    run("rem.m7d2", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, DL);
    run("div.7dm2", DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, DL);
    run("rem.7dm2", REM, 32'd7, 32'hFFFFFFFE, 32'd1, DL);
    run("remu.100d7", REMU, 32'd100, 32'd7, 32'd2, DL);

    // Back-to-back: second START is driven while the first is in DONE.
    run("b2b.divu", DIVU, 32'd9, 32'd2, 32'd4, DL);
    run("b2b.remu", REMU, 32'd9, 32'd2, 32'd1, DL);

    // Kill mid-divide; RESULT keeps the previous value.
    @(posedge clk); #1;
    issue(DIVU, 32'd100, 32'd7);
    repeat (8) begin @(posedge clk); #1; end
    kill = 1'b1;
    #1;
    chk("kill.busy", {31'b0, busy}, 32'd1);
    chk("kill.ready_low", {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    kill = 1'b0;
    #1;
    chk("kill.valid", {31'b0, valid}, 32'd0);
    chk("kill.ready", {31'b0, ready}, 32'd1);
    chk("kill.busy_after", {31'b0, busy}, 32'd0);
    chk("kill.result", result, 32'd1);
    vcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (valid) vcnt++; end
    chk("kill.novalid", 32'(vcnt), 32'd0);

    // Fresh DIVU with a START pulse mid-run that must be ignored.
    issue(DIVU, 32'd100, 32'd7);
    n = 1;
    while (!valid && n < 100) begin
      if (n == 3) begin op = REMU; data2 = 32'h0; start = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk("divu.100d7", result, 32'd14);
    chk("divu.100d7.lat", 32'(n), 32'd34);

    // Async reset mid-multiply.
    @(posedge clk); #1;
    issue(MUL, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.ready", {31'b0, ready}, 32'd1);
    chk("arst.busy", {31'b0, busy}, 32'd0);
    chk("arst.valid", {31'b0, valid}, 32'd0);
    chk("arst.result", result, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    vcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (valid) vcnt++; end
    chk("arst.novalid", 32'(vcnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
